// File: rtl/counter_modn_prog.sv
// Runtime-programmable modulo counter: up/down, load, one-shot start/done FSM,
// registered terminal-count pulse and saturating wrap-event counter. All outputs registered.
module counter_modn_prog #(
  parameter int Bits      = 8,
  parameter int Wrap_Bits = 4
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 En,
  input  logic [Bits-1:0]      Max_Count,
  input  logic                 Up_Dn,
  input  logic                 Mode,
  input  logic                 Start,
  input  logic                 Load,
  input  logic [Bits-1:0]      Load_Val,
  output logic [Bits-1:0]      out,
  output logic                 Tc,
  output logic                 Busy,
  output logic                 Done,
  output logic [Wrap_Bits-1:0] Wrap_Cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q;
  logic [Bits-1:0]      out_q;
  logic                 tc_q;
  logic                 busy_q;
  logic                 done_q;
  logic [Wrap_Bits-1:0] wrap_q;

  logic [Bits-1:0]      step_d;
  logic [Bits-1:0]      term_d;
  logic [Bits-1:0]      load_d;
  logic                 wrap_ev_d;
  logic [Wrap_Bits-1:0] wrap_inc_d;

  // A count above Max_Count (after Max_Count was lowered) wraps on the next step.
  always_comb begin
    step_d    = out_q;
    wrap_ev_d = 1'b0;
    if (Up_Dn) begin
      wrap_ev_d = (out_q >= Max_Count);
      step_d    = wrap_ev_d ? '0 : out_q + 1'b1;
    end else begin
      wrap_ev_d = (out_q == '0) || (out_q > Max_Count);
      step_d    = wrap_ev_d ? Max_Count : out_q - 1'b1;
    end
    term_d     = Up_Dn ? Max_Count : '0;
    load_d     = (Load_Val > Max_Count) ? Max_Count : Load_Val;
    wrap_inc_d = (wrap_q == '1) ? wrap_q : wrap_q + 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      out_q   <= '0;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= '0;
    end else if (Load) begin
      out_q  <= load_d;
      wrap_q <= '0;
      tc_q   <= 1'b0;
      if (!Mode) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end
    end else if (!Mode) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tc_q    <= En && wrap_ev_d;
      if (En) begin
        out_q <= step_d;
        if (wrap_ev_d) wrap_q <= wrap_inc_d;
      end
    end else begin
      // One-shot runs report completion through Done only, never Tc.
      tc_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (Start) begin
            out_q   <= Up_Dn ? '0 : Max_Count;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (En) begin
            out_q <= step_d;
            if (step_d == term_d) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out      = out_q;
  assign Tc       = tc_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Wrap_Cnt = wrap_q;

endmodule

// File: doc/counter_modn_prog.md
Name: counter_modn_prog

Overview:
- Parametrised, runtime-programmable modulo counter. It is the next-generation general timing primitive for the EMG front-end control: sample-rate dividers, channel sequencing and settling timers.
- Adds the following over a fixed-modulus free-running counter: runtime modulus, up/down direction, count enable, synchronous load, one-shot mode with start/done handshake, registered terminal-count pulse, and a saturating wrap counter.

Parameters:
- Bits, 8, counter width; out range 0..2^Bits-1.
- Wrap_Bits, 4, width of the saturating wrap-event counter.

Ports:
- Clk  input  1  single clock; all state changes on posedge Clk.
- Reset  input  1  synchronous, active-high reset.
- En  input  1  count enable; out holds when low.
- Max_Count  input  Bits  runtime terminal value; sampled every cycle.
- Up_Dn  input  1  1 = count up, 0 = count down.
- Mode  input  1  0 = continuous, 1 = one-shot.
- Start  input  1  one-shot launch; ignored when Mode=0.
- Load  input  1  synchronous load strobe.
- Load_Val  input  Bits  load value.
- out  output  Bits  registered count.
- Tc  output  1  registered terminal-count pulse, one cycle wide.
- Busy  output  1  one-shot run in progress.
- Done  output  1  one-shot finished; held until restart or Reset.
- Wrap_Cnt  output  Wrap_Bits  number of Tc events, saturating.

Behaviour:
- Priority per cycle: Reset > Load > Start > count.
- Reset: out=0, Tc=0, Busy=0, Done=0, Wrap_Cnt=0, state=IDLE. Reset asserted mid-run aborts the run with no Tc.
- Load:
  - out <= min(Load_Val, Max_Count); Wrap_Cnt <= 0; Tc=0.
  - State is unchanged; a one-shot run continues from the loaded value.
- Terminal value: Max_Count when Up_Dn=1, 0 when Up_Dn=0.
- Count step (En=1, counting permitted):
  - Up: if out >= Max_Count then out <= 0, else out <= out+1. Using >= means lowering Max_Count below out wraps on the next step.
  - Down: if out == 0 or out > Max_Count then out <= Max_Count, else out <= out-1.
  - Tc=1 in exactly the cycle in which out shows the post-wrap value (0 up, Max_Count down); Tc=0 otherwise.
  - En=0 holds out and forces Tc=0.
- Max_Count=0: out stays 0; Tc=1 on every enabled cycle.
- Wrap_Cnt increments on each Tc, saturates at 2^Wrap_Bits-1, and clears only on Reset or Load.
- Up_Dn may change on any cycle; it takes effect on the next step with no Tc from the direction change itself.
- Mode=0 (continuous):
  - Counts whenever En=1, regardless of state.
  - Busy=0, Done=0; state forced to IDLE.
- Mode=1 (one-shot) FSM:
  - IDLE: on Start, out <= start value (0 if Up_Dn=1, Max_Count if Up_Dn=0), Busy=1, Done=0, go to RUN. No count that cycle.
  - RUN: count per the rules above while En=1. The step that reaches the terminal value goes to DONE; out holds the terminal value, Tc=0.
  - DONE: Busy=0, Done=1, out frozen. Start re-launches exactly as from IDLE; Start and Done drop in the same cycle.
  - Start during RUN is ignored.
  - Run length with En held high = N+1 cycles from Start to Done, where N = Max_Count; Max_Count=0 gives Done one cycle after launch.
  - In one-shot mode Tc is never asserted; completion is signalled by Done.
- Mode changed mid-run: switching to 0 drops Busy/Done next cycle and continues counting; switching to 1 enters IDLE.
- All outputs registered; no combinational path from input to output.

Test Plan:
1. Reset, Bits=8, Mode=0, Up_Dn=1, Max_Count=4, En=1 for 12 cycles -> out 0,1,2,3,4,0,1,2,3,4,0,1; Tc high in the cycles out=0 after a wrap; Wrap_Cnt=2.
2. Continuous, Up_Dn=0, Max_Count=3, Load with Load_Val=9 -> out=3; then 3,2,1,0,3 with Tc at the second 3. Hold En=0 for 3 cycles -> out frozen, Tc=0.
3. Mode=1, Up_Dn=1, Max_Count=5, Start pulse -> Busy high; out 0..5; Done=1 with out=5, Busy=0; Tc never asserted. Start again -> out=0, Done=0.
4. Mode=1 mid-run at out=2, assert Reset for one cycle -> out=0, Busy=0, Done=0, Wrap_Cnt=0, no Tc.
5. Continuous up with Max_Count=10, out=8; change Max_Count to 5 -> next cycle out=0 with Tc=1. Max_Count=0 -> out=0 and Tc=1 every enabled cycle.
6. Wrap_Bits=4, Max_Count=0, En=1 for 20 cycles -> Wrap_Cnt saturates at 15. Load asserted simultaneously with Start in IDLE -> load wins, FSM stays IDLE.
